// File: rtl/processor_pkg.sv
// Shared processor definitions: opcode map, program base address and the
// program loader state encoding.
package processor_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OPCODE_MAX = 4'h9;

    localparam logic [11:0] PROGRAM_BASE      = 12'h100;
    localparam logic [7:0]  LOADER_START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_DATA    = 3'd5,
        ST_CHECK   = 3'd6,
        ST_FINISH  = 3'd7
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: byte stream in (valid/ready), memory write port and status out.
// A byte transfers on a rising clk edge where in_valid && in_ready; the source
// holds in_data stable while in_valid is high and in_ready low.
interface program_loader_if;
    import processor_pkg::*;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [11:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic          busy;
    loader_state_e state;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, load_done, load_error, busy, state
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, load_done, load_error, busy, state
    );

endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader writing 32-bit words into program memory.
// Optional build macro LOADER_OPCODE_CHECK_EN rejects words with undefined opcodes.
module program_loader
    import processor_pkg::*;
#(
    parameter logic [7:0]  START_BYTE   = LOADER_START_BYTE,
    parameter logic [11:0] DEFAULT_BASE = PROGRAM_BASE
) (
    input  logic             clk,
    input  logic             reset_n,
    program_loader_if.master bus
);

    loader_state_e state, next_state;

    logic [11:0] addr_q;
    logic [11:0] count_q;
    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic [7:0]  cks_q;
    logic        ok_q;
    logic        mem_we_q;
    logic [11:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        in_ready;

    logic        fire;
    logic [31:0] word_full;
    logic        word_done;
    logic        opcode_bad;

    assign fire      = bus.in_valid && in_ready;
    assign word_full = {word_q[23:0], bus.in_data};
    assign word_done = fire && (state == ST_DATA) && (byte_idx == 2'd3);

`ifdef LOADER_OPCODE_CHECK_EN
    assign opcode_bad = (word_full[31:28] > OPCODE_MAX);
`else
    assign opcode_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b1;
        case (state)
            ST_IDLE:    if (fire && bus.in_data == START_BYTE) next_state = ST_ADDR_HI;
            ST_ADDR_HI: if (fire) next_state = ST_ADDR_LO;
            ST_ADDR_LO: if (fire) next_state = ST_CNT_HI;
            ST_CNT_HI:  if (fire) next_state = ST_CNT_LO;
            ST_CNT_LO: begin
                if (fire)
                    next_state = ({count_q[11:8], bus.in_data} == 12'd0) ? ST_CHECK : ST_DATA;
            end
            ST_DATA: begin
                if (word_done) begin
                    if (opcode_bad)            next_state = ST_FINISH;
                    else if (count_q == 12'd1) next_state = ST_CHECK;
                end
            end
            ST_CHECK:   if (fire) next_state = ST_FINISH;
            ST_FINISH: begin
                // One dead cycle that carries the done/error pulse.
                in_ready   = 1'b0;
                next_state = ST_IDLE;
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q      <= '0;
            count_q     <= '0;
            byte_idx    <= '0;
            word_q      <= '0;
            cks_q       <= '0;
            ok_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (fire) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.in_data == START_BYTE) begin
                            cks_q    <= '0;
                            byte_idx <= '0;
                            word_q   <= '0;
                        end
                    end
                    ST_ADDR_HI: begin
                        addr_q <= {bus.in_data[3:0], addr_q[7:0]};
                        cks_q  <= cks_q ^ bus.in_data;
                    end
                    ST_ADDR_LO: begin
                        addr_q <= {addr_q[11:8], bus.in_data};
                        cks_q  <= cks_q ^ bus.in_data;
                    end
                    ST_CNT_HI: begin
                        count_q <= {bus.in_data[3:0], count_q[7:0]};
                        cks_q   <= cks_q ^ bus.in_data;
                    end
                    ST_CNT_LO: begin
                        count_q <= {count_q[11:8], bus.in_data};
                        cks_q   <= cks_q ^ bus.in_data;
                        if (addr_q == 12'hFFF) addr_q <= DEFAULT_BASE;
                    end
                    ST_DATA: begin
                        cks_q    <= cks_q ^ bus.in_data;
                        word_q   <= word_full;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (opcode_bad) begin
                                ok_q <= 1'b0;
                            end else begin
                                // Write lands the cycle after the 4th byte.
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= addr_q;
                                mem_wdata_q <= word_full;
                                addr_q      <= addr_q + 12'd1;
                                count_q     <= count_q - 12'd1;
                            end
                        end
                    end
                    ST_CHECK:  ok_q <= (bus.in_data == cks_q);
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = (state != ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.load_done  = (state == ST_FINISH) && ok_q;
    assign bus.load_error = (state == ST_FINISH) && !ok_q;
    assign bus.state      = state;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames against a frame-level reference model.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset_n;
    program_loader_if bus();

    program_loader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [43:0] exp_q[$];
    logic [43:0] got_q[$];
    logic [31:0] word_q[$];
    int done_cnt;
    int err_cnt;

    // Memory write and pulse observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.mem_we === 1'b1) got_q.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.load_done === 1'b1) done_cnt++;
            if (bus.load_error === 1'b1) err_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 3);
            bus.in_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic rand_words(input int n);
        logic [31:0] w;
        word_q.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            w[31:28] = 4'($urandom_range(0, 9));
            word_q.push_back(w);
        end
    endtask

    // Builds the frame from word_q, predicts writes and outcome, then sends it.
    task automatic run_frame(input logic [11:0] a, input bit flip, input bit gaps,
                             input logic [3:0] junk);
        logic [7:0]  bytes[$];
        logic [7:0]  cks;
        logic [11:0] n;
        logic [11:0] base;
        logic [31:0] w;
        bit          aborted;
        bit          exp_done;
        n = 12'(word_q.size());
        bytes.delete();
        exp_q.delete();
        bytes.push_back(8'hA5);
        bytes.push_back({junk, a[11:8]});
        bytes.push_back(a[7:0]);
        bytes.push_back({junk, n[11:8]});
        bytes.push_back(n[7:0]);
        base = (a == 12'hFFF) ? 12'h100 : a;
        aborted = 1'b0;
        for (int i = 0; i < word_q.size(); i++) begin
            w = word_q[i];
            for (int j = 3; j >= 0; j--) bytes.push_back(w[8*j +: 8]);
`ifdef LOADER_OPCODE_CHECK_EN
            if (!aborted && w[31:28] > 4'h9) aborted = 1'b1;
`endif
            if (!aborted) exp_q.push_back({12'(base + 12'(i)), w});
        end
        cks = 8'h00;
        for (int i = 1; i < bytes.size(); i++) cks ^= bytes[i];
        if (flip) cks ^= 8'h01;
        bytes.push_back(cks);
        exp_done = !flip && !aborted;

        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        send_byte(bytes[0], gaps);
        check("hold_after_start", 64'(bus.cpu_hold), 64'd1);
        for (int i = 1; i < bytes.size(); i++) send_byte(bytes[i], gaps);
        if (!aborted) begin
            check("finish_done", 64'(bus.load_done), 64'(exp_done));
            check("finish_error", 64'(bus.load_error), 64'(!exp_done));
            check("finish_ready", 64'(bus.in_ready), 64'd0);
            check("finish_hold", 64'(bus.cpu_hold), 64'd1);
            @(negedge clk);
            check("hold_release", 64'(bus.cpu_hold), 64'd0);
            check("ready_release", 64'(bus.in_ready), 64'd1);
        end
        repeat (3) @(negedge clk);
        check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("write", 64'(got_q[i]), 64'(exp_q[i]));
        check("done_cnt", 64'(done_cnt), 64'(exp_done));
        check("err_cnt", 64'(err_cnt), 64'(!exp_done));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_hold"}, 64'(bus.cpu_hold), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_we"}, 64'(bus.mem_we), 64'd0);
        check({tag, "_done"}, 64'(bus.load_done), 64'd0);
        check({tag, "_err"}, 64'(bus.load_error), 64'd0);
    endtask

    initial begin
        logic [3:0]  jk;
        logic [11:0] ra;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_addr", 64'(bus.mem_addr), 64'd0);
        check("reset_wdata", 64'(bus.mem_wdata), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Junk before a frame is ignored.
        send_byte(8'h3C, 1'b0);
        check("junk_idle_hold", 64'(bus.cpu_hold), 64'd0);

        word_q = '{32'h11005003, 32'h80000000};
        run_frame(12'h100, 1'b0, 1'b0, 4'h0);

        rand_words(1);
        run_frame(12'hFFF, 1'b0, 1'b0, 4'h0);

        rand_words(3);
        run_frame(12'hFFE, 1'b0, 1'b1, 4'h0);

        rand_words(2);
        run_frame(12'h040, 1'b1, 1'b0, 4'h0);

        word_q.delete();
        run_frame(12'h100, 1'b0, 1'b0, 4'h0);
        run_frame(12'h100, 1'b0, 1'b1, 4'h0);

        // Abort mid-word with reset, then a fresh frame.
        got_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        check("midreset_writes", 64'(got_q.size()), 64'd0);
        check("midreset_pulses", 64'(done_cnt + err_cnt), 64'd0);
        rand_words(2);
        run_frame(12'h300, 1'b0, 1'b0, 4'h0);

        for (int k = 0; k < 4; k++) begin
            jk = 4'($urandom_range(0, 15));
            ra = 12'($urandom_range(0, 4095));
            rand_words($urandom_range(1, 4));
            run_frame(ra, 1'($urandom_range(0, 1)), 1'b1, jk);
        end

`ifdef LOADER_OPCODE_CHECK_EN
        word_q = '{32'h12345678, 32'hF0000000};
        run_frame(12'h200, 1'b0, 1'b0, 4'h0);
        rand_words(1);
        run_frame(12'h210, 1'b0, 1'b0, 4'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
